// File: rtl/reverser_serial_unit.sv
// reverser_serial_unit: selects operand A or B and reverses it either bit-by-bit
// or in GROUP-bit chunks. The order of bits inside each chunk is kept.
// Valid/ready handshakes on the input and output sides. FSM: IDLE -> SHIFT -> DONE.
// Default build: one reversal step per clock (WIDTH steps, or WIDTH/GROUP steps).
// Define REVERSER_FAST_EN to finish SHIFT in a single cycle. The handshake is unchanged.
module reverser_serial_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  input  logic             Mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned NumGroups = WIDTH / GROUP;
  localparam int unsigned CntW      = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             last_step;

`ifdef REVERSER_FAST_EN
  // Full bit reversal of the operand.
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = v[int'(WIDTH) - 1 - i];
    end
    return r;
  endfunction

  // Reversal of the chunk order. Bits keep their order inside each chunk.
  function automatic logic [WIDTH-1:0] grp_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int g = 0; g < int'(NumGroups); g++) begin
      for (int b = 0; b < int'(GROUP); b++) begin
        r[g * int'(GROUP) + b] = v[(int'(NumGroups) - 1 - g) * int'(GROUP) + b];
      end
    end
    return r;
  endfunction

  assign last_step = 1'b1;
`else
  localparam logic [CntW-1:0] LastBitStep = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] LastGrpStep = CntW'(NumGroups - 1);

  // The step that is in progress is the final one for the latched mode.
  assign last_step = (cnt_q == (mode_q ? LastGrpStep : LastBitStep));
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StShift;
      StShift: if (last_step) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers: operand shifter, partial result, step counter, result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      res_q  <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      res_q  <= res_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  // Datapath next-state: latch at acceptance, step in SHIFT, load Out on the last step
  always_comb begin
    sr_d   = sr_q;
    res_d  = res_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sr_d   = Sel ? B : A;
          mode_d = Mode;
          res_d  = '0;
          cnt_d  = '0;
        end
      end
      StShift: begin
`ifdef REVERSER_FAST_EN
        res_d = mode_q ? grp_rev(sr_q) : bit_rev(sr_q);
`else
        if (mode_q) begin
          res_d = {res_q[WIDTH-GROUP-1:0], sr_q[GROUP-1:0]};
          sr_d  = sr_q >> GROUP;
        end else begin
          res_d = {res_q[WIDTH-2:0], sr_q[0]};
          sr_d  = sr_q >> 1;
        end
`endif
        cnt_d = cnt_q + CntW'(1);
        if (last_step) begin
          out_d = res_d;
        end
      end
      default: ;
    endcase
  end

  // Handshake outputs come only from the registered state
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  assign Out = out_q;

endmodule

// File: tb/tb_reverser_serial_unit.sv
// Self-checking bench for reverser_serial_unit (WIDTH=8, GROUP=4).
// Expected results are pushed to a scoreboard queue when a request is sent.
// They are popped and compared when out_valid is seen.
module tb_reverser_serial_unit;

  localparam int unsigned W = 8;
`ifdef REVERSER_FAST_EN
  localparam int LatBit = 1;
  localparam int LatGrp = 1;
`else
  localparam int LatBit = 8;
  localparam int LatGrp = 2;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A = '0, B = '0;
  logic         Sel = 1'b0, Mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] Out;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  reverser_serial_unit #(.WIDTH(8), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .Mode      (Mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Out       (Out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 mirrors bit order, mode 1 swaps the two nibbles.
  function automatic logic [W-1:0] ref_rev(input logic [W-1:0] v, input logic m);
    logic [W-1:0] r;
    if (m) begin
      r = {v[3:0], v[7:4]};
    end else begin
      for (int i = 0; i < 8; i++) r[7-i] = v[i];
    end
    return r;
  endfunction

  // Present one request for a single edge, then scramble the inputs.
  // Called at #1 after an edge while the DUT is idle.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                      input logic m, input bit push);
    A = a; B = b; Sel = sel; Mode = m; in_valid = 1'b1;
    if (push) exp_q.push_back(ref_rev(sel ? b : a, m));
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = ~a; B = ~b; Sel = ~sel; Mode = ~m;
  endtask

  // Bounded wait for out_valid. Returns the number of edges counted since acceptance.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (Out !== 8'h00) begin fails++; $display("FAIL reset_out: got %h want 00", Out); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_bit_reverse();
    int cyc;
    logic [W-1:0] e;
    send(8'b0000_0001, 8'h00, 1'b0, 1'b0, 1'b1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bit_busy: got %b want 1", busy); end
    wait_valid(cyc);
    e = exp_q.pop_front();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bit_timeout: out_valid %b want 1", out_valid); end
    tests++; if (cyc != LatBit) begin fails++; $display("FAIL bit_latency: got %0d want %0d", cyc, LatBit); end
    tests++; if (Out !== e) begin fails++; $display("FAIL bit_out: got %h want %h", Out, e); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bit_release: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_sel_b();
    int cyc;
    logic [W-1:0] e;
    send(8'hFF, 8'b1010_0011, 1'b1, 1'b0, 1'b1);
    wait_valid(cyc);
    e = exp_q.pop_front();
    tests++; if (cyc != LatBit) begin fails++; $display("FAIL selb_latency: got %0d want %0d", cyc, LatBit); end
    tests++; if (Out !== e) begin fails++; $display("FAIL selb_out: got %h want %h", Out, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_group_back_to_back();
    int cyc;
    logic [W-1:0] e;
    logic [W-1:0] vals [2] = '{8'h3C, 8'h12};
    for (int k = 0; k < 2; k++) begin
      send(vals[k], 8'h00, 1'b0, 1'b1, 1'b1);
      wait_valid(cyc);
      e = exp_q.pop_front();
      tests++; if (cyc != LatGrp) begin fails++; $display("FAIL grp_latency[%0d]: got %0d want %0d", k, cyc, LatGrp); end
      tests++; if (Out !== e) begin fails++; $display("FAIL grp_out[%0d]: got %h want %h", k, Out, e); end
      @(posedge clk); #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL grp_ready[%0d]: got %b want 1", k, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [W-1:0] e;
    out_ready = 1'b0;
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_valid(cyc);
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      tests++; if (out_valid !== 1'b1 || Out !== e || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: out_valid %b Out %h in_ready %b want 1 %h 0", k, out_valid, Out, in_ready, e);
      end
      A = 8'hA5; Sel = 1'b0; in_valid = (k % 2 == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_release: in_ready %b busy %b out_valid %b want 1 0 0", in_ready, busy, out_valid);
    end
    tests++; if (Out !== e) begin fails++; $display("FAIL bp_retain: got %h want %h", Out, e); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_no_accept: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid_shift();
    int cyc;
    logic [W-1:0] e;
    send(8'hAA, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || Out !== 8'h00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: out_valid %b in_ready %b Out %h busy %b want 0 1 00 0", out_valid, in_ready, Out, busy);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(8'h0F, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_valid(cyc);
    e = exp_q.pop_front();
    tests++; if (cyc != LatBit) begin fails++; $display("FAIL rst_after_latency: got %0d want %0d", cyc, LatBit); end
    tests++; if (Out !== e) begin fails++; $display("FAIL rst_after_out: got %h want %h", Out, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int cyc;
    logic [W-1:0] e, a, b;
    logic s, m;
    for (int k = 0; k < 8; k++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom); m = 1'($urandom);
      send(a, b, s, m, 1'b1);
      wait_valid(cyc);
      e = exp_q.pop_front();
      tests++; if (cyc != (m ? LatGrp : LatBit)) begin
        fails++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, cyc, m ? LatGrp : LatBit);
      end
      tests++; if (Out !== e) begin fails++; $display("FAIL rand_out[%0d]: got %h want %h", k, Out, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_bit_reverse();
    test_sel_b();
    test_group_back_to_back();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reverser_serial_unit.md
# reverser_serial_unit

Parametrised, sequential successor of the 4-bit A/B reverser used in the ALSU reverse operations. Selects operand A or B, then reverses it either bit-by-bit or in GROUP-bit chunks, one step per clock, under a valid/ready handshake on both sides. It sits behind the ALSU operation decoder, and its registered result feeds the ALSU output mux.

## Interface
- WIDTH, 8, operand and result width; WIDTH >= 2
- GROUP, 4, chunk size for group mode; WIDTH % GROUP == 0 and 1 <= GROUP < WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high; single clock domain
- A  input  WIDTH  operand 0
- B  input  WIDTH  operand 1
- Sel  input  1  0 selects A, 1 selects B
- Mode  input  1  0 = bit reverse (step 1 bit); 1 = group reverse (step GROUP bits, bit order inside each group preserved)
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- Out  output  WIDTH  registered result
- out_valid  output  1  Out holds a completed result
- out_ready  input  1  consumer accepts Out
- busy  output  1  high in SHIFT or DONE

## Operation
- Step count N: N = WIDTH if Mode=0, N = WIDTH/GROUP if Mode=1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clk edge: latch sr = Sel ? B : A, latch Mode, clear res and step counter, go to SHIFT.
- SHIFT, one step per edge:
  - Mode 0: res = {res[WIDTH-2:0], sr[0]}; sr >>= 1.
  - Mode 1: res = {res[WIDTH-GROUP-1:0], sr[GROUP-1:0]}; sr >>= GROUP.
  - On the Nth step, load Out from the final res value and go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - Out is held stable until out_ready=1 at an edge, then return to IDLE.
  - No same-cycle accept of a new request.
- A, B, Sel and Mode are sampled only at acceptance. Changes during SHIFT or DONE are ignored.
- in_valid outside IDLE is ignored. No queueing: the producer holds in_valid until it sees in_ready.
- out_ready outside DONE is ignored.
- Out retains its last result after DONE→IDLE until the next completion overwrites it.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, Out=0, out_valid=0, in_ready=1, busy=0.
  - Internal sr, res and counter are cleared.
- Latency: out_valid rises N edges after the acceptance edge.
  - WIDTH=8, Mode 0: 8 cycles.
  - WIDTH=8, GROUP=4, Mode 1: 2 cycles.
- Minimum cycles between acceptances: N+2 (accept, N steps, one DONE cycle with out_ready=1).
- in_ready, out_valid and busy are decoded directly from registered state (no combinational path from inputs).
- Reset mid-SHIFT or mid-DONE aborts the operation with no result emitted. In-flight data is lost. The first edge after reset release may accept a new request.

## Configuration
- REVERSER_FAST_EN defined: SHIFT completes in a single cycle (full reversal computed combinationally from the latched operand), so N=1 for both modes. The FSM, handshake and reset behaviour are unchanged.
- REVERSER_FAST_EN undefined: serial stepping as above (default build).

## Test plan
- WIDTH=8, GROUP=4 unless noted; out_ready=1 unless noted.
- A=8'b0000_0001, Sel=0, Mode=0 → Out=8'b1000_0000. out_valid rises 8 cycles after accept and stays high 1 cycle.
- B=8'b1010_0011, A=8'hFF, Sel=1, Mode=0 → Out=8'b1100_0101. A is ignored.
- Mode=1: A=8'h3C → Out=8'hC3 with latency 2; then A=8'h12 → Out=8'h21.
- Backpressure: complete A=8'h01, Mode 0, holding out_ready=0 for 5 cycles. Required: out_valid=1 and Out=8'h80 stable, in_ready=0, and in_valid pulses with other data ignored. After out_ready=1: IDLE, in_ready=1.
- Reset during the 3rd SHIFT step → out_valid=0, Out=0, in_ready=1 immediately. A following request A=8'h0F, Mode 0 → Out=8'hF0.
- With REVERSER_FAST_EN: A=8'h01, Mode 0 → Out=8'h80 after 1 cycle; A=8'h3C, Mode 1 → Out=8'hC3 after 1 cycle.
